// File: rtl/c432_pkg.sv
// Shared constants and types for the c432 27-channel interrupt controller.
package c432_pkg;
  localparam int NLINES = 9;
  localparam int CHAN_W = 4;
  localparam logic [CHAN_W-1:0] CHAN_IDLE = 4'hF;

  typedef logic [NLINES-1:0] line_vec_t;
  typedef logic [CHAN_W-1:0] chan_t;
endpackage

// File: rtl/top_level_432_if.sv
// Request/grant bundle of the c432 interrupt controller: three request buses, enable mask, grant outputs.
interface top_level_432_if;
  import c432_pkg::*;

  line_vec_t E_in;
  line_vec_t A_in;
  line_vec_t B_in;
  line_vec_t C_in;
  logic      PA_out;
  logic      PB_out;
  logic      PC_out;
  chan_t     Chan_out;

  modport master (
    output E_in, A_in, B_in, C_in,
    input  PA_out, PB_out, PC_out, Chan_out
  );

  modport slave (
    input  E_in, A_in, B_in, C_in,
    output PA_out, PB_out, PC_out, Chan_out
  );
endinterface

// File: rtl/c432_core.sv
// Combinational c432 arbiter: bus priority A > B > C, then lowest enabled line index.
module c432_core
  import c432_pkg::*;
(
  input  line_vec_t i_e,
  input  line_vec_t i_a,
  input  line_vec_t i_b,
  input  line_vec_t i_c,
  output logic      o_pa,
  output logic      o_pb,
  output logic      o_pc,
  output chan_t     o_chan
);

  // Scan from the top so the lowest set bit is the last one written.
  function automatic chan_t lsb_enc(input line_vec_t v);
    chan_t enc;
    enc = CHAN_IDLE;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (v[i]) enc = CHAN_W'(i);
    end
    return enc;
  endfunction

  line_vec_t w_req_a;
  line_vec_t w_req_b;
  line_vec_t w_req_c;
  line_vec_t w_sel;

  assign w_req_a = i_a & i_e;
  assign w_req_b = i_b & i_e;
  assign w_req_c = i_c & i_e;

  always_comb begin
    o_pa  = |w_req_a;
    o_pb  = ~o_pa & (|w_req_b);
    o_pc  = ~o_pa & ~o_pb & (|w_req_c);
    w_sel = '0;
    if (o_pa)      w_sel = w_req_a;
    else if (o_pb) w_sel = w_req_b;
    else if (o_pc) w_sel = w_req_c;
    o_chan = lsb_enc(w_sel);
  end

endmodule

// File: rtl/top_level_432.sv
// Registered wrapper around the c432 arbiter: input bank, combinational core, output bank (2-edge latency).
module top_level_432
  import c432_pkg::*;
(
  input logic              clk,
  input logic              rst,
  top_level_432_if.slave   bus
);

  line_vec_t r_e_p0;
  line_vec_t r_a_p0;
  line_vec_t r_b_p0;
  line_vec_t r_c_p0;

  logic      w_pa;
  logic      w_pb;
  logic      w_pc;
  chan_t     w_chan;

  logic      r_pa_p1;
  logic      r_pb_p1;
  logic      r_pc_p1;
  chan_t     r_chan_p1;

  // Stage 0: input capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_p0 <= '0;
      r_a_p0 <= '0;
      r_b_p0 <= '0;
      r_c_p0 <= '0;
    end else begin
      r_e_p0 <= bus.E_in;
      r_a_p0 <= bus.A_in;
      r_b_p0 <= bus.B_in;
      r_c_p0 <= bus.C_in;
    end
  end

  // Stage 1: arbitration on registered inputs
  c432_core u_core (
    .i_e    (r_e_p0),
    .i_a    (r_a_p0),
    .i_b    (r_b_p0),
    .i_c    (r_c_p0),
    .o_pa   (w_pa),
    .o_pb   (w_pb),
    .o_pc   (w_pc),
    .o_chan (w_chan)
  );

  // Stage 2: output capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pa_p1   <= 1'b0;
      r_pb_p1   <= 1'b0;
      r_pc_p1   <= 1'b0;
      r_chan_p1 <= CHAN_IDLE;
    end else begin
      r_pa_p1   <= w_pa;
      r_pb_p1   <= w_pb;
      r_pc_p1   <= w_pc;
      r_chan_p1 <= w_chan;
    end
  end

  assign bus.PA_out   = r_pa_p1;
  assign bus.PB_out   = r_pb_p1;
  assign bus.PC_out   = r_pc_p1;
  assign bus.Chan_out = r_chan_p1;

endmodule

// File: tb/tb_top_level_432.sv
// Directed bench for top_level_432: reset, priority, masking, pipelining and mid-stream reset.
module tb_top_level_432;
  import c432_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  top_level_432_if ifc ();

  top_level_432 dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [8:0] e, input logic [8:0] a,
                       input logic [8:0] b, input logic [8:0] c);
    ifc.E_in = e;
    ifc.A_in = a;
    ifc.B_in = b;
    ifc.C_in = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected packed as {PA, PB, PC, Chan}.
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {ifc.PA_out, ifc.PB_out, ifc.PC_out, ifc.Chan_out};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed PA/PB/PC=%b Chan=%h expected PA/PB/PC=%b Chan=%h",
             tag, obs[6:4], obs[3:0], exp[6:4], exp[3:0]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);

    tick(); chk("reset_edge1", 7'b000_1111);
    tick(); chk("reset_edge2", 7'b000_1111);

    rst = 1'b0;
    drive(9'h1FF, 9'h002, 9'h002, 9'h002);
    tick(); chk("latency_first_edge", 7'b000_1111);
    tick(); chk("a_beats_bc_line1", 7'b100_0001);

    drive(9'h1FD, 9'h002, 9'h002, 9'h002);
    tick(); tick(); chk("line1_masked", 7'b000_1111);

    drive(9'h000, 9'h002, 9'h001, 9'h000);
    tick(); tick(); chk("all_masked", 7'b000_1111);

    drive(9'h03C, 9'h004, 9'h003, 9'h007);
    tick(); tick(); chk("pa_chan2", 7'b100_0010);

    drive(9'h004, 9'h003, 9'h004, 9'h004);
    tick(); tick(); chk("a_masked_pb_chan2", 7'b010_0010);

    drive(9'h003, 9'h007, 9'h004, 9'h004);
    tick(); tick(); chk("pa_chan0", 7'b100_0000);

    drive(9'h010, 9'h000, 9'h000, 9'h018);
    tick(); tick(); chk("pc_chan4", 7'b001_0100);

    drive(9'h0FF, 9'h100, 9'h000, 9'h080);
    tick(); tick(); chk("a_line8_masked_pc_chan7", 7'b001_0111);

    drive(9'h1FF, 9'h000, 9'h100, 9'h000);
    tick(); tick(); chk("pb_chan8", 7'b010_1000);

    // Back-to-back vectors, one per cycle.
    drive(9'h1FF, 9'h020, 9'h000, 9'h000);
    tick();
    drive(9'h1FF, 9'h000, 9'h040, 9'h000);
    tick(); chk("b2b_v1_pa_chan5", 7'b100_0101);
    drive(9'h1FF, 9'h000, 9'h000, 9'h001);
    tick(); chk("b2b_v2_pb_chan6", 7'b010_0110);
    drive(9'h000, 9'h000, 9'h000, 9'h000);
    tick(); chk("b2b_v3_pc_chan0", 7'b001_0000);
    tick(); chk("b2b_drain_idle", 7'b000_1111);

    // Reset mid-stream drops both in-flight vectors.
    drive(9'h1FF, 9'h020, 9'h000, 9'h000);
    tick();
    drive(9'h1FF, 9'h000, 9'h040, 9'h000);
    rst = 1'b1;
    tick(); chk("midrst_drop_v1", 7'b000_1111);
    rst = 1'b0;
    drive(9'h000, 9'h000, 9'h000, 9'h000);
    tick(); chk("midrst_drop_v2", 7'b000_1111);

    drive(9'h1FF, 9'h000, 9'h000, 9'h100);
    tick(); tick(); chk("after_reset_pc_chan8", 7'b001_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
